// File: rtl/nabp_image_writer.sv
// Back-projection image writer: buffers PE beats, scales and saturates each lane's
// accumulator, and writes one pixel per cycle to image RAM with a frame-done pulse.
module nabp_image_writer #(
   parameter int NO_OF_PE    = 4,
   parameter int ACC_W       = 24,
   parameter int PIX_W       = 16,
   parameter int FRAC_SHIFT  = 8,
   parameter int X_W         = 8,
   parameter int Y_W         = 8,
   parameter int IMAGE_W     = 256,
   parameter int IMAGE_H     = 256,
   parameter int PART_STRIDE = 64,
   parameter int ADDR_W      = 16
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      pe_valid,
   output logic                      pe_ready,
   input  logic [NO_OF_PE*ACC_W-1:0] pe_vals,
   input  logic [X_W-1:0]            pe_x,
   input  logic [Y_W-1:0]            pe_y,
   input  logic                      pe_last,
   input  logic                      im_ready,
   output logic                      im_we,
   output logic [ADDR_W-1:0]         im_addr,
   output logic [PIX_W-1:0]          im_data,
   output logic                      done,
   output logic [15:0]               skipped
);

   localparam int          LANE_W  = (NO_OF_PE > 1) ? $clog2(NO_OF_PE) : 1;
   localparam int          ROW_W   = Y_W + $clog2(NO_OF_PE * PART_STRIDE);
   localparam logic [63:0] PIX_MAX = (64'd1 << PIX_W) - 64'd1;

   typedef enum logic [1:0] {S_IDLE, S_WRITE, S_DONE} state_t;

   function automatic logic [PIX_W-1:0] sat_pix(input logic signed [ACC_W-1:0] acc);
      logic signed [ACC_W-1:0] sh;
      sh = acc >>> FRAC_SHIFT;
      if (sh < 0)
         sat_pix = '0;
      else if (64'($unsigned(sh)) > PIX_MAX)
         sat_pix = '1;
      else
         sat_pix = PIX_W'($unsigned(sh));
   endfunction

   logic [NO_OF_PE*ACC_W-1:0] r_fifo_vals [2];
   logic [X_W-1:0]            r_fifo_x    [2];
   logic [Y_W-1:0]            r_fifo_y    [2];
   logic                      r_fifo_last [2];
   logic                      r_wptr;
   logic                      r_rptr;
   logic [1:0]                r_count;
   logic                      r_ready;

   state_t                    r_state;
   state_t                    w_state_nx;
   logic [LANE_W-1:0]         r_lane;
   logic [LANE_W-1:0]         w_lane_nx;
   logic [15:0]               r_skipped;

   logic                      w_push;
   logic                      w_pop;
   logic                      w_we;
   logic                      w_skip;
   logic                      w_adv;
   logic                      w_done;
   logic                      w_oor;
   logic [1:0]                w_count_nx;
   logic [ROW_W-1:0]          w_row;
   logic [ADDR_W-1:0]         w_addr;
   logic signed [ACC_W-1:0]   w_acc;
   logic [PIX_W-1:0]          w_pix;

   assign w_push     = pe_valid & r_ready;
   assign w_count_nx = r_count + {1'b0, w_push} - {1'b0, w_pop};

   // Ready is registered from next occupancy so RAM backpressure never reaches pe_ready combinationally.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_wptr  <= 1'b0;
         r_rptr  <= 1'b0;
         r_count <= 2'd0;
         r_ready <= 1'b0;
      end else begin
         if (w_push) r_wptr <= ~r_wptr;
         if (w_pop)  r_rptr <= ~r_rptr;
         r_count <= w_count_nx;
         r_ready <= (w_count_nx != 2'd2);
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_fifo_vals[r_wptr] <= pe_vals;
         r_fifo_x[r_wptr]    <= pe_x;
         r_fifo_y[r_wptr]    <= pe_y;
         r_fifo_last[r_wptr] <= pe_last;
      end
   end

   // The head stays in the buffer while its lanes are written; it is popped after the last lane.
   always_comb begin
      w_acc  = signed'(r_fifo_vals[r_rptr][ACC_W*r_lane +: ACC_W]);
      w_row  = ROW_W'(r_fifo_y[r_rptr]) + ROW_W'(r_lane) * ROW_W'(PART_STRIDE);
      w_oor  = (32'(w_row) >= 32'(IMAGE_H)) || (32'(r_fifo_x[r_rptr]) >= 32'(IMAGE_W));
      w_addr = ADDR_W'(w_row) * ADDR_W'(IMAGE_W) + ADDR_W'(r_fifo_x[r_rptr]);
      w_pix  = sat_pix(w_acc);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= S_IDLE;
         r_lane    <= '0;
         r_skipped <= '0;
      end else begin
         r_state <= w_state_nx;
         r_lane  <= w_lane_nx;
         if (w_skip && (r_skipped != 16'hFFFF))
            r_skipped <= r_skipped + 16'd1;
      end
   end

   always_comb begin
      w_state_nx = r_state;
      w_lane_nx  = r_lane;
      w_pop      = 1'b0;
      w_we       = 1'b0;
      w_skip     = 1'b0;
      w_adv      = 1'b0;
      w_done     = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (r_count != 2'd0) begin
               w_state_nx = S_WRITE;
               w_lane_nx  = '0;
            end
         end
         S_WRITE: begin
            w_skip = w_oor;
            w_we   = ~w_oor;
            w_adv  = w_oor | im_ready;
            if (w_adv) begin
               if (r_lane == LANE_W'(NO_OF_PE - 1)) begin
                  w_pop     = 1'b1;
                  w_lane_nx = '0;
                  if (r_fifo_last[r_rptr])
                     w_state_nx = S_DONE;
                  else if (r_count == 2'd2)
                     w_state_nx = S_WRITE;
                  else
                     w_state_nx = S_IDLE;
               end else begin
                  w_lane_nx = r_lane + LANE_W'(1);
               end
            end
         end
         S_DONE: begin
            w_done     = 1'b1;
            w_state_nx = S_IDLE;
         end
         default: w_state_nx = S_IDLE;
      endcase
   end

   assign pe_ready = r_ready;
   assign im_we    = w_we;
   assign im_addr  = w_we ? w_addr : '0;
   assign im_data  = w_we ? w_pix : '0;
   assign done     = w_done;
   assign skipped  = r_skipped;

endmodule

// File: tb/tb_nabp_image_writer.sv
// Randomized bench for nabp_image_writer: an event-queue reference model predicts
// every RAM write and done pulse from the accepted beats.
module tb_nabp_image_writer;
   localparam int NO_OF_PE = 4, ACC_W = 24, PIX_W = 16, FRAC_SHIFT = 8, X_W = 8, Y_W = 8;
   localparam int IMAGE_W = 256, IMAGE_H = 256, PART_STRIDE = 64, ADDR_W = 16;

   logic                      clk = 1'b0;
   logic                      reset;
   logic                      pe_valid;
   logic                      pe_ready;
   logic [NO_OF_PE*ACC_W-1:0] pe_vals;
   logic [X_W-1:0]            pe_x;
   logic [Y_W-1:0]            pe_y;
   logic                      pe_last;
   logic                      im_ready;
   logic                      im_we;
   logic [ADDR_W-1:0]         im_addr;
   logic [PIX_W-1:0]          im_data;
   logic                      done;
   logic [15:0]               skipped;

   nabp_image_writer #(
      .NO_OF_PE(NO_OF_PE), .ACC_W(ACC_W), .PIX_W(PIX_W), .FRAC_SHIFT(FRAC_SHIFT),
      .X_W(X_W), .Y_W(Y_W), .IMAGE_W(IMAGE_W), .IMAGE_H(IMAGE_H),
      .PART_STRIDE(PART_STRIDE), .ADDR_W(ADDR_W)
   ) dut (
      .clk(clk), .reset(reset), .pe_valid(pe_valid), .pe_ready(pe_ready),
      .pe_vals(pe_vals), .pe_x(pe_x), .pe_y(pe_y), .pe_last(pe_last),
      .im_ready(im_ready), .im_we(im_we), .im_addr(im_addr), .im_data(im_data),
      .done(done), .skipped(skipped)
   );

   always #5 clk = ~clk;

   typedef struct {bit is_done; int addr; int data;} ev_t;
   ev_t ev_q[$];

   int n_chk = 0, n_pass = 0;
   int model_skip = 0;
   int cyc = 0;
   int wr_cnt, done_cnt, first_wr_cyc, last_wr_cyc, done_cyc, acc_cyc;
   int rdy_mode = 0;
   int pat_idx = 0;

   task automatic chk(input string tag, input longint got, input longint exp);
      n_chk++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   function automatic int pix_of(input logic [ACC_W-1:0] v);
      int a, q;
      a = int'(v);
      if (v[ACC_W-1]) a = a - (1 << ACC_W);
      q = a >>> FRAC_SHIFT;
      if (q < 0) return 0;
      if (q > (1 << PIX_W) - 1) return (1 << PIX_W) - 1;
      return q;
   endfunction

   task automatic model_beat(input logic [NO_OF_PE*ACC_W-1:0] vals, input int x, input int y,
                             input bit last);
      ev_t e;
      for (int l = 0; l < NO_OF_PE; l++) begin
         int row;
         row = y + l * PART_STRIDE;
         if (row < IMAGE_H && x < IMAGE_W) begin
            e.is_done = 1'b0;
            e.addr    = (row * IMAGE_W + x) % (1 << ADDR_W);
            e.data    = pix_of(vals[l*ACC_W +: ACC_W]);
            ev_q.push_back(e);
         end else if (model_skip < 65535) begin
            model_skip++;
         end
      end
      if (last) begin
         e.is_done = 1'b1; e.addr = 0; e.data = 0;
         ev_q.push_back(e);
      end
   endtask

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   initial begin
      im_ready = 1'b0;
      forever begin
         @(posedge clk); #1;
         case (rdy_mode)
            0:       im_ready = 1'b1;
            1:       im_ready = ($urandom_range(0, 3) != 0);
            default: begin im_ready = (pat_idx % 3 == 0); pat_idx++; end
         endcase
      end
   end

   // Monitor: compares observed writes/done against the predicted event order.
   initial begin
      logic              hold_v;
      logic [ADDR_W-1:0] hold_a;
      logic [PIX_W-1:0]  hold_d;
      ev_t               e;
      hold_v = 1'b0; hold_a = '0; hold_d = '0;
      forever begin
         @(negedge clk);
         if (reset) begin
            hold_v = 1'b0;
         end else begin
            if (hold_v) begin
               chk("stall_we", im_we, 1);
               chk("stall_addr", im_addr, hold_a);
               chk("stall_data", im_data, hold_d);
            end
            hold_v = im_we && !im_ready;
            hold_a = im_addr;
            hold_d = im_data;
            if (im_we && im_ready) begin
               if (wr_cnt == 0) first_wr_cyc = cyc;
               last_wr_cyc = cyc;
               wr_cnt++;
               chk("write_expected", (ev_q.size() != 0 && !ev_q[0].is_done), 1);
               if (ev_q.size() != 0 && !ev_q[0].is_done) begin
                  e = ev_q.pop_front();
                  chk("wr_addr", im_addr, e.addr);
                  chk("wr_data", im_data, e.data);
               end
            end
            if (done) begin
               done_cnt++;
               done_cyc = cyc;
               chk("done_expected", (ev_q.size() != 0 && ev_q[0].is_done), 1);
               if (ev_q.size() != 0 && ev_q[0].is_done) void'(ev_q.pop_front());
            end
            if (pe_valid && pe_ready) begin
               acc_cyc = cyc;
               model_beat(pe_vals, int'(pe_x), int'(pe_y), pe_last);
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic clear_stats();
      wr_cnt = 0; done_cnt = 0; first_wr_cyc = 0; last_wr_cyc = 0; done_cyc = 0; acc_cyc = 0;
   endtask

   function automatic logic [NO_OF_PE*ACC_W-1:0] rand_vals();
      logic [NO_OF_PE*ACC_W-1:0] v;
      for (int l = 0; l < NO_OF_PE; l++) begin
         case ($urandom_range(0, 4))
            0:       v[l*ACC_W +: ACC_W] = 24'h7FFFFF;
            1:       v[l*ACC_W +: ACC_W] = 24'h800000;
            2:       v[l*ACC_W +: ACC_W] = 24'($urandom_range(0, 1023));
            default: v[l*ACC_W +: ACC_W] = 24'($urandom);
         endcase
      end
      return v;
   endfunction

   // Called just after a rising edge; returns just after the accepting edge.
   task automatic send_beat(input logic [NO_OF_PE*ACC_W-1:0] vals, input int x, input int y,
                            input bit last);
      bit acc;
      int t;
      pe_valid = 1'b1; pe_vals = vals; pe_x = X_W'(x); pe_y = Y_W'(y); pe_last = last;
      acc = 1'b0; t = 0;
      while (!acc && t < 2000) begin
         @(negedge clk);
         acc = pe_ready;
         t++;
         @(posedge clk); #1;
      end
      chk("send_accepted", acc, 1);
      pe_valid = 1'b0; pe_last = 1'b0;
   endtask

   task automatic drain(input string tag);
      int t;
      t = 0;
      while (ev_q.size() != 0 && t < 5000) begin
         @(negedge clk);
         t++;
      end
      repeat (4) @(negedge clk);
      chk({tag, "_drained"}, ev_q.size(), 0);
      chk({tag, "_skipped"}, skipped, model_skip);
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      reset = 1'b1;
      ev_q.delete();
      model_skip = 0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      @(posedge clk); #1;
   endtask

   initial begin
      int x1, y1;
      reset = 1'b1; pe_valid = 1'b0; pe_vals = '0; pe_x = '0; pe_y = '0; pe_last = 1'b0;
      clear_stats();
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_ready", pe_ready, 0);
      chk("rst_we", im_we, 0);
      chk("rst_addr", im_addr, 0);
      chk("rst_data", im_data, 0);
      chk("rst_done", done, 0);
      chk("rst_skipped", skipped, 0);
      @(posedge clk); #1 reset = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("ready_after_rst", pe_ready, 1);
      @(posedge clk); #1;

      // Single beat: latency, consecutive writes, done one cycle later.
      rdy_mode = 0;
      clear_stats();
      send_beat({24'h000400, 24'h000300, 24'h000200, 24'h000100}, 3, 0, 1'b1);
      drain("t1");
      chk("t1_writes", wr_cnt, 4);
      chk("t1_latency", first_wr_cyc - acc_cyc, 2);
      chk("t1_consecutive", last_wr_cyc - first_wr_cyc, 3);
      chk("t1_done_cnt", done_cnt, 1);
      chk("t1_done_delay", done_cyc - last_wr_cyc, 1);

      // Saturation extremes.
      clear_stats();
      send_beat({24'h800000, 24'h00FF80, 24'h7FFFFF, 24'hFFFF00}, 10, 5, 1'b1);
      drain("t2");
      chk("t2_writes", wr_cnt, 4);

      // Backpressure with three back-to-back beats.
      rdy_mode = 2;
      pat_idx = 0;
      clear_stats();
      send_beat(rand_vals(), $urandom_range(0, 255), $urandom_range(0, 63), 1'b0);
      send_beat(rand_vals(), $urandom_range(0, 255), $urandom_range(0, 63), 1'b0);
      @(negedge clk);
      chk("t3_ready_full", pe_ready, 0);
      @(posedge clk); #1;
      send_beat(rand_vals(), $urandom_range(0, 255), $urandom_range(0, 63), 1'b1);
      drain("t3");
      chk("t3_writes", wr_cnt, 12);
      chk("t3_done_cnt", done_cnt, 1);

      // Out-of-range lanes.
      rdy_mode = 0;
      do_reset();
      clear_stats();
      send_beat(rand_vals(), 7, 200, 1'b1);
      drain("t4");
      chk("t4_writes", wr_cnt, 1);
      chk("t4_skipped3", skipped, 3);
      chk("t4_done_cnt", done_cnt, 1);

      // Reset during lane 2 of the first beat with a second beat buffered.
      clear_stats();
      x1 = $urandom_range(0, 255);
      y1 = $urandom_range(0, 63);
      send_beat(rand_vals(), x1, y1, 1'b1);
      send_beat(rand_vals(), $urandom_range(0, 255), $urandom_range(0, 63), 1'b1);
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("t5_lane2_we", im_we, 1);
      chk("t5_lane2_addr", im_addr, (y1 + 2 * PART_STRIDE) * IMAGE_W + x1);
      reset = 1'b1;
      ev_q.delete();
      model_skip = 0;
      @(posedge clk);
      @(negedge clk);
      chk("t5_we", im_we, 0);
      chk("t5_done", done, 0);
      chk("t5_skipped", skipped, 0);
      chk("t5_ready", pe_ready, 0);
      @(posedge clk); #1 reset = 1'b0;
      clear_stats();
      repeat (12) @(posedge clk);
      #1;
      chk("t5_idle_writes", wr_cnt, 0);
      chk("t5_idle_done", done_cnt, 0);
      send_beat(rand_vals(), $urandom_range(0, 255), $urandom_range(0, 63), 1'b1);
      drain("t5");
      chk("t5_new_writes", wr_cnt, 4);
      chk("t5_new_done", done_cnt, 1);

      // Full-rate stream of 256 beats.
      clear_stats();
      for (int i = 0; i < 256; i++)
         send_beat(rand_vals(), i, 0, (i == 255));
      drain("t6");
      chk("t6_writes", wr_cnt, 1024);
      chk("t6_consecutive", last_wr_cyc - first_wr_cyc, 1023);
      chk("t6_done_cnt", done_cnt, 1);
      chk("t6_done_delay", done_cyc - last_wr_cyc, 1);

      // Random frames with random backpressure, gaps and ranges.
      rdy_mode = 1;
      for (int f = 0; f < 4; f++) begin
         int nb;
         nb = $urandom_range(3, 10);
         clear_stats();
         for (int b = 0; b < nb; b++) begin
            send_beat(rand_vals(), $urandom_range(0, 255), $urandom_range(0, 255), (b == nb - 1));
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
         end
         drain("t7");
         chk("t7_done_cnt", done_cnt, 1);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
